// File: rtl/dps_sci_pkg.sv
// Shared constants and FSM encoding for the DPS SCI stream master.
// Address map, CFG word bit positions and the CFG word builder.
package dps_sci_pkg;

  localparam logic [1:0] SCITX  = 2'd0;
  localparam logic [1:0] SCIRX  = 2'd1;
  localparam logic [1:0] SCICFG = 2'd2;

  localparam int CFG_TEN  = 0;
  localparam int CFG_REN  = 1;
  localparam int CFG_BDR  = 2;
  localparam int CFG_TIRE = 6;
  localparam int CFG_RIRE = 9;
  localparam int CFG_TCLR = 12;
  localparam int CFG_RCLR = 13;

  typedef enum logic [2:0] {
    ST_UNCFG,
    ST_CFG,
    ST_IDLE,
    ST_ACK,
    ST_RD,
    ST_WAIT,
    ST_OUT
  } state_t;

  function automatic logic [31:0] cfg_word(
    input logic [3:0] bdr,
    input logic [2:0] lvl
  );
    logic [31:0] w;
    w = '0;
    w[CFG_TEN] = 1'b1;
    w[CFG_REN] = 1'b1;
    w[CFG_BDR +: 4] = bdr;
    w[CFG_TIRE +: 3] = lvl;
    w[CFG_RIRE +: 3] = lvl;
    w[CFG_TCLR] = 1'b1;
    w[CFG_RCLR] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/dps_sci_stream_master.sv
// Bus initiator for the DPS SCI: config, TX stream push, IRQ-driven RX drain.
// Optional periodic RX poll enabled by DPS_SCI_STREAM_MASTER_POLL_EN.
module dps_sci_stream_master
  import dps_sci_pkg::*;
#(
  parameter logic [2:0] P_IRQ_LEVEL   = 3'h1,
  parameter logic [2:0] P_RSP_TIMEOUT = 3'd4
`ifdef DPS_SCI_STREAM_MASTER_POLL_EN
  ,
  parameter logic [7:0] P_POLL_PERIOD = 8'd255
`endif
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iCFG_START,
  input  logic [3:0]  iCFG_BDR,
  output logic        oCFG_DONE,
  input  logic        iTX_VALID,
  output logic        oTX_READY,
  input  logic [7:0]  iTX_DATA,
  output logic        oRX_VALID,
  input  logic        iRX_READY,
  output logic [7:0]  oRX_DATA,
  output logic        oREQ_VALID,
  output logic        oREQ_RW,
  output logic [1:0]  oREQ_ADDR,
  output logic [31:0] oREQ_DATA,
  input  logic        iREQ_BUSY,
  input  logic        iREQ_VALID,
  input  logic [31:0] iREQ_DATA,
  input  logic        iIRQ_VALID,
  output logic        oIRQ_ACK,
  output logic        oERR
);

  localparam logic [2:0] TMO_LAST = P_RSP_TIMEOUT - 3'd1;

  state_t     state_q;
  logic [3:0] bdr_q;
  logic       cfg_pend_q;
  logic [2:0] tmo_q;
  logic       cfg_req;
  logic       tx_fire;
  logic       poll_hit;
  logic       unused_rsp;

  assign unused_rsp = ^iREQ_DATA[30:8];
  assign cfg_req    = cfg_pend_q | iCFG_START;
  assign oTX_READY  = (state_q == ST_IDLE) & ~iIRQ_VALID
                    & ~cfg_req & ~iREQ_BUSY;
  assign tx_fire    = oTX_READY & iTX_VALID;
  assign oIRQ_ACK   = (state_q == ST_ACK);

`ifdef DPS_SCI_STREAM_MASTER_POLL_EN
  localparam logic [7:0] POLL_LOAD = P_POLL_PERIOD - 8'd1;

  logic [7:0] poll_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      poll_q <= POLL_LOAD;
    end else if (state_q != ST_IDLE || tx_fire) begin
      poll_q <= POLL_LOAD;
    end else if (poll_q != 8'd0) begin
      poll_q <= poll_q - 8'd1;
    end
  end

  assign poll_hit = (state_q == ST_IDLE) & (poll_q == 8'd0) & ~tx_fire;
`else
  assign poll_hit = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= ST_UNCFG;
      bdr_q      <= '0;
      cfg_pend_q <= 1'b0;
      tmo_q      <= '0;
      oCFG_DONE  <= 1'b0;
      oRX_VALID  <= 1'b0;
      oRX_DATA   <= '0;
      oERR       <= 1'b0;
    end else begin
      if (iCFG_START) begin
        bdr_q <= iCFG_BDR;
        oERR  <= 1'b0;
      end
      if (iCFG_START && state_q != ST_IDLE && state_q != ST_UNCFG)
        cfg_pend_q <= 1'b1;
      unique case (state_q)
        ST_UNCFG: if (iCFG_START) state_q <= ST_CFG;
        ST_CFG: begin
          oCFG_DONE <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cfg_req) begin
            cfg_pend_q <= 1'b0;
            state_q    <= ST_CFG;
          end else if (iIRQ_VALID) begin
            state_q <= ST_ACK;
          end else if (poll_hit) begin
            state_q <= ST_RD;
          end
        end
        ST_ACK: state_q <= ST_RD;
        ST_RD: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // bit 31 of the RX word flags a valid byte; clear means FIFO empty
          if (iREQ_VALID) begin
            if (iREQ_DATA[31]) begin
              oRX_DATA  <= iREQ_DATA[7:0];
              oRX_VALID <= 1'b1;
              state_q   <= ST_OUT;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (tmo_q == TMO_LAST) begin
            oERR    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 3'd1;
          end
        end
        ST_OUT: begin
          if (iRX_READY) begin
            oRX_VALID <= 1'b0;
            state_q   <= ST_RD;
          end
        end
        default: state_q <= ST_UNCFG;
      endcase
    end
  end

  always_comb begin
    oREQ_VALID = 1'b0;
    oREQ_RW    = 1'b0;
    oREQ_ADDR  = SCITX;
    oREQ_DATA  = '0;
    unique case (1'b1)
      state_q == ST_CFG: begin
        oREQ_VALID = 1'b1;
        oREQ_RW    = 1'b1;
        oREQ_ADDR  = SCICFG;
        oREQ_DATA  = cfg_word(bdr_q, P_IRQ_LEVEL);
      end
      state_q == ST_RD: begin
        oREQ_VALID = 1'b1;
        oREQ_ADDR  = SCIRX;
      end
      tx_fire: begin
        oREQ_VALID = 1'b1;
        oREQ_RW    = 1'b1;
        oREQ_ADDR  = SCITX;
        oREQ_DATA  = {24'h0, iTX_DATA};
      end
      default: ;
    endcase
  end

endmodule
